// File: rtl/tile_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : tile_addr_gen_if
// Description : Register-block / DMA-side bundle for tile_addr_gen. The
//               slave modport is the generator; master is the driving side.
// Revision    : 1.0 - initial release
// ============================================================================
interface tile_addr_gen_if #(
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
);
  logic              I_TAG_START;
  logic [DIM_W-1:0]  I_TAG_HEIGHT;
  logic [DIM_W-1:0]  I_TAG_WIDTH;
  logic [1:0]        I_TAG_DEGREES;
  logic              I_TAG_DIRECTION;
  logic              I_TAG_MIRROR;
  logic [ADDR_W-1:0] I_TAG_SRC_BASE;
  logic [ADDR_W-1:0] I_TAG_DST_BASE;
  logic              I_TAG_DMA_READY;
  logic              O_TAG_VALID;
  logic [ADDR_W-1:0] O_TAG_ADDR;
  logic              O_TAG_WRITE;
  logic [15:0]       O_TAG_BYTES;
  logic              O_TAG_BUSY;
  logic              O_TAG_DONE;
  logic              O_TAG_ERR;

  modport slave (
    input  I_TAG_START, I_TAG_HEIGHT, I_TAG_WIDTH, I_TAG_DEGREES,
           I_TAG_DIRECTION, I_TAG_MIRROR, I_TAG_SRC_BASE, I_TAG_DST_BASE,
           I_TAG_DMA_READY,
    output O_TAG_VALID, O_TAG_ADDR, O_TAG_WRITE, O_TAG_BYTES,
           O_TAG_BUSY, O_TAG_DONE, O_TAG_ERR
  );

  modport master (
    output I_TAG_START, I_TAG_HEIGHT, I_TAG_WIDTH, I_TAG_DEGREES,
           I_TAG_DIRECTION, I_TAG_MIRROR, I_TAG_SRC_BASE, I_TAG_DST_BASE,
           I_TAG_DMA_READY,
    input  O_TAG_VALID, O_TAG_ADDR, O_TAG_WRITE, O_TAG_BYTES,
           O_TAG_BUSY, O_TAG_DONE, O_TAG_ERR
  );
endinterface
`default_nettype wire

// File: rtl/tile_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tile_addr_gen
// Description : Tile-by-tile DMA line-burst request generator for the rotate
//               engine. Per tile: TILE source-line reads, then TILE
//               destination-line writes placed for 0/90/180/270 rotation.
//               Optional feature macro: TAG_MIRROR_EN (horizontal flip of
//               the output tile columns).
// Revision    : 1.0 - initial release
// ============================================================================
module tile_addr_gen #(
  parameter int TILE   = 8,
  parameter int BPP    = 3,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  wire logic        I_TAG_HCLK,
  input  wire logic        I_TAG_HRESET_N,
  tile_addr_gen_if.slave   bus
);
  localparam int LOG2T = $clog2(TILE);
  // Product width: wide enough for (row*stride+col)*BPP and for the address.
  localparam int MW = (ADDR_W > 2*DIM_W+4) ? ADDR_W : 2*DIM_W+4;
  localparam logic [15:0] C_BYTES = 16'(TILE*BPP);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;

  state_t            r_state, w_next;
  logic [DIM_W-1:0]  r_ntr, r_ntc, r_tr, r_tc;
  logic [LOG2T-1:0]  r_line;
  logic [1:0]        r_ang;
  logic [ADDR_W-1:0] r_src, r_dst;
  logic              r_done, r_err;
  logic              w_load, w_set_done, w_set_err;
  logic              w_accept, w_last_line, w_last_tile, w_geom_ok;
  logic [DIM_W:0]    w_h_pad, w_w_pad;
  logic [DIM_W-1:0]  w_ntr, w_ntc;
  logic [MW-1:0]     w_pw, w_ph, w_otr, w_otc, w_ntoc;
  logic [MW-1:0]     w_row, w_col, w_stride, w_off;
  logic [ADDR_W-1:0] w_addr;

  // Tile counts from raw geometry, rounded up to whole tiles.
  assign w_h_pad   = {1'b0, bus.I_TAG_HEIGHT} + (DIM_W+1)'(TILE-1);
  assign w_w_pad   = {1'b0, bus.I_TAG_WIDTH}  + (DIM_W+1)'(TILE-1);
  assign w_ntr     = DIM_W'(w_h_pad >> LOG2T);
  assign w_ntc     = DIM_W'(w_w_pad >> LOG2T);
  assign w_geom_ok = (bus.I_TAG_HEIGHT != '0) && (bus.I_TAG_WIDTH != '0);

  assign w_accept    = (r_state != S_IDLE) && bus.I_TAG_DMA_READY;
  assign w_last_line = (r_line == LOG2T'(TILE-1));
  assign w_last_tile = (r_tr == r_ntr - DIM_W'(1)) && (r_tc == r_ntc - DIM_W'(1));

`ifdef TAG_MIRROR_EN
  logic r_mirror;
`else
  // Mirror request has no effect in this build.
  logic w_unused_mirror;
  assign w_unused_mirror = bus.I_TAG_MIRROR;
`endif

  // State register.
  always_ff @(posedge I_TAG_HCLK or negedge I_TAG_HRESET_N) begin
    if (!I_TAG_HRESET_N) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  // Next-state logic: read phase, write phase, then next tile or finish.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_set_done = 1'b0;
    w_set_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.I_TAG_START) begin
          if (w_geom_ok) begin
            w_next = S_RD;
            w_load = 1'b1;
          end else begin
            w_set_err = 1'b1;
          end
        end
      end
      S_RD: if (w_accept && w_last_line) w_next = S_WR;
      S_WR: begin
        if (w_accept && w_last_line) begin
          if (w_last_tile) begin
            w_next     = S_IDLE;
            w_set_done = 1'b1;
          end else begin
            w_next = S_RD;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Job parameters latched at start; line/tile counters advance on acceptance.
  always_ff @(posedge I_TAG_HCLK or negedge I_TAG_HRESET_N) begin
    if (!I_TAG_HRESET_N) begin
      r_ntr  <= '0;
      r_ntc  <= '0;
      r_tr   <= '0;
      r_tc   <= '0;
      r_line <= '0;
      r_ang  <= '0;
      r_src  <= '0;
      r_dst  <= '0;
`ifdef TAG_MIRROR_EN
      r_mirror <= 1'b0;
`endif
    end else if (w_load) begin
      r_ntr  <= w_ntr;
      r_ntc  <= w_ntc;
      r_tr   <= '0;
      r_tc   <= '0;
      r_line <= '0;
      // CCW by d is CW by (4-d) mod 4, i.e. the two's-complement negation.
      r_ang  <= bus.I_TAG_DIRECTION ? bus.I_TAG_DEGREES : 2'(2'd0 - bus.I_TAG_DEGREES);
      r_src  <= bus.I_TAG_SRC_BASE;
      r_dst  <= bus.I_TAG_DST_BASE;
`ifdef TAG_MIRROR_EN
      r_mirror <= bus.I_TAG_MIRROR;
`endif
    end else if (w_accept) begin
      r_line <= r_line + LOG2T'(1);
      if (r_state == S_WR && w_last_line && !w_last_tile) begin
        if (r_tc == r_ntc - DIM_W'(1)) begin
          r_tc <= '0;
          r_tr <= r_tr + DIM_W'(1);
        end else begin
          r_tc <= r_tc + DIM_W'(1);
        end
      end
    end
  end

  // One-cycle completion and rejection pulses.
  always_ff @(posedge I_TAG_HCLK or negedge I_TAG_HRESET_N) begin
    if (!I_TAG_HRESET_N) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_set_done;
      r_err  <= w_set_err;
    end
  end

  // Destination tile placement and burst address for the current request.
  always_comb begin
    w_pw = MW'(r_ntc) << LOG2T;
    w_ph = MW'(r_ntr) << LOG2T;
    case (r_ang)
      2'd1:    begin w_otr = MW'(r_tc);                   w_otc = MW'(r_ntr - DIM_W'(1) - r_tr); end
      2'd2:    begin w_otr = MW'(r_ntr - DIM_W'(1) - r_tr); w_otc = MW'(r_ntc - DIM_W'(1) - r_tc); end
      2'd3:    begin w_otr = MW'(r_ntc - DIM_W'(1) - r_tc); w_otc = MW'(r_tr);                   end
      default: begin w_otr = MW'(r_tr);                   w_otc = MW'(r_tc);                   end
    endcase
    w_ntoc = r_ang[0] ? MW'(r_ntr) : MW'(r_ntc);
`ifdef TAG_MIRROR_EN
    if (r_mirror) w_otc = w_ntoc - MW'(1) - w_otc;
`endif
    if (r_state == S_WR) begin
      w_row    = (w_otr << LOG2T) + MW'(r_line);
      w_col    = w_otc << LOG2T;
      w_stride = r_ang[0] ? w_ph : w_pw;
    end else begin
      w_row    = (MW'(r_tr) << LOG2T) + MW'(r_line);
      w_col    = MW'(r_tc) << LOG2T;
      w_stride = w_pw;
    end
    w_off  = (w_row * w_stride + w_col) * MW'(BPP);
    w_addr = ((r_state == S_WR) ? r_dst : r_src) + w_off[ADDR_W-1:0];
  end

  assign bus.O_TAG_VALID = (r_state != S_IDLE);
  assign bus.O_TAG_BUSY  = (r_state != S_IDLE);
  assign bus.O_TAG_WRITE = (r_state == S_WR);
  assign bus.O_TAG_ADDR  = (r_state == S_IDLE) ? '0 : w_addr;
  assign bus.O_TAG_BYTES = C_BYTES;
  assign bus.O_TAG_DONE  = r_done;
  assign bus.O_TAG_ERR   = r_err;
endmodule
`default_nettype wire
